// File: rtl/aes_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// aes_cipher_ctrl
//
// Flow controller for a pipelined AES round datapath with Nr+1 register
// stages. Tracks which stages hold a block, drives the per-stage load enables
// as an elastic (valid/ready) pipeline, carries a user tag beside every block,
// and sequences round-key changes. A key change stops new input, lets the
// in-flight blocks drain, then grants a single-cycle key-update slot.
//
// Parameters
//   Nk     key length in 32-bit words (4/6/8)
//   Nr     number of rounds; the pipeline has Nr+1 stages
//   TAG_W  width of the per-block tag
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active-high
//   in_valid   plaintext block offered this cycle
//   in_ready   block accepted this cycle
//   in_tag     tag of the offered block
//   stage_en   per-stage load enable to the datapath, bit i drives stage i
//   out_valid  ciphertext valid at the datapath output (stage Nr)
//   out_ready  downstream accepts the ciphertext
//   out_tag    tag of the block in stage Nr
//   key_req    round-key change request, held high until key_ack
//   key_ack    one-cycle pulse: pipeline empty, round key may change now
//   busy       any stage occupied or key sequencer not idle
//
// Optional feature (compile-time macro AES_CTRL_PERF_EN)
//   perf_blocks  count of out_valid & out_ready cycles (wraps at 2^32)
//   perf_stall   count of out_valid & !out_ready cycles (wraps at 2^32)
// -----------------------------------------------------------------------------
module aes_cipher_ctrl #(
  parameter int Nk    = 4,
  parameter int Nr    = Nk + 6,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  output logic [Nr:0]      stage_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  input  logic             key_req,
  output logic             key_ack,
  output logic             busy
`ifdef AES_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_blocks,
  output logic [31:0]      perf_stall
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ACK
  } key_state_e;

  key_state_e       state_q, state_d;
  logic [Nr:0]      occ_q, occ_d;
  logic [Nr:0]      free;
  logic [TAG_W-1:0] tag_q [0:Nr];

  // A stage is free when it is empty or everything downstream of it can
  // move this cycle; this is what lets bubbles collapse.
  always_comb begin : free_ripple
    logic ripple;
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    free   = '0;
    ripple = out_ready;
    for (int i = Nr; i >= 0; i--) begin
      ripple  = ripple | ~occ_q[i];
      free[i] = ripple;
    end
  end

  // key_req wins over in_valid in the same cycle. rst gates in_ready
  // because an empty pipe would otherwise look ready during reset.
  assign in_ready = ~rst & free[0] & (state_q == ST_IDLE) & ~key_req;

  always_comb begin
    stage_en    = '0;
    stage_en[0] = in_valid & in_ready;
    for (int i = 1; i <= Nr; i++) begin
      stage_en[i] = occ_q[i-1] & free[i];
    end
  end

  // A stage stays full unless its block moves on; it refills when loaded.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < Nr; i++) begin
      occ_d[i] = stage_en[i] | (occ_q[i] & ~stage_en[i+1]);
    end
    occ_d[Nr] = stage_en[Nr] | (occ_q[Nr] & ~out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
      // NOTE: the tag array is small and must read as zero after reset,
      // so it is reset here; wide data memories normally are not.
      for (int i = 0; i <= Nr; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignment so every stage
      // samples its predecessor's pre-edge value, giving a true shift.
      occ_q <= occ_d;
      if (stage_en[0]) tag_q[0] <= in_tag;
      for (int i = 1; i <= Nr; i++) begin
        if (stage_en[i]) tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Key-change sequencer: IDLE -> DRAIN on request, DRAIN -> ACK once the
  // pipe is empty, ACK lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (key_req) state_d = ST_DRAIN;
      ST_DRAIN: if (occ_q == '0) state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign out_valid = occ_q[Nr];
  assign out_tag   = tag_q[Nr];
  assign key_ack   = (state_q == ST_ACK);
  assign busy      = (|occ_q) | (state_q != ST_IDLE);

`ifdef AES_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_blocks <= '0;
      perf_stall  <= '0;
    end else begin
      if (out_valid & out_ready)  perf_blocks <= perf_blocks + 32'd1;
      if (out_valid & ~out_ready) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
